// File: rtl/dso_rd_sched_if.sv
// Control/readout bundle between the run-control/display side and the
// capture/readout scheduler.
interface dso_rd_sched_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              run_req;
    logic              single_req;
    logic              wave_ready;
    logic              rd_start;
    logic              wave_run;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] wave_rd_addr;
    logic              ram_rd_over;
    logic              rd_valid;
    logic              force_trig;
    logic              busy;
    logic [15:0]       frame_cnt;

    modport master (
        output run_req, single_req, wave_ready, rd_start,
        input  wave_run, ram_rd_en, wave_rd_addr, ram_rd_over, rd_valid, force_trig, busy,
               frame_cnt
    );

    modport slave (
        input  run_req, single_req, wave_ready, rd_start,
        output wave_run, ram_rd_en, wave_rd_addr, ram_rd_over, rd_valid, force_trig, busy,
               frame_cnt
    );
endinterface

// File: rtl/dso_rd_sched.sv
// Capture/readout scheduler: arms capture, waits for a held frame, streams POINTS
// wave-RAM addresses per display request. Optional auto trigger: DSO_AUTO_TRIG_EN.
module dso_rd_sched #(
    parameter int unsigned POINTS       = 640,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned AUTO_TIMEOUT = 2_000_000
) (
    input logic           clk,
    input logic           rst,
    dso_rd_sched_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StCapt, StPend, StRead, StRearm} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(POINTS - 1);

    state_e            st_q, st_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              single_q, single_d;
    logic              wave_run_q, rd_en_q, over_q, busy_q, force_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       frame_q;
    logic [RD_LAT-1:0] lat_q;
    logic              cont_drop;

    // Dropping run_req only stops an acquisition that is not single-shot.
    assign cont_drop = !bus.run_req && !single_q;

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        single_d = single_q;
        unique case (st_q)
            StIdle: begin
                if (bus.run_req) begin
                    st_d     = StCapt;
                    single_d = 1'b0;
                end else if (bus.single_req) begin
                    st_d     = StCapt;
                    single_d = 1'b1;
                end
            end
            StCapt: begin
                if (cont_drop)           st_d = StIdle;
                else if (bus.wave_ready) st_d = StPend;
            end
            StPend: begin
                if (cont_drop) begin
                    st_d = StIdle;
                end else if (bus.rd_start) begin
                    st_d  = StRead;
                    cnt_d = '0;
                end
            end
            StRead: begin
                if (cnt_q == LastAddr) st_d = StRearm;
                else                   cnt_d = cnt_q + ADDR_W'(1);
            end
            StRearm: begin
                st_d     = (bus.run_req && !single_q) ? StCapt : StIdle;
                single_d = 1'b0;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= StIdle;
            cnt_q      <= '0;
            single_q   <= 1'b0;
            wave_run_q <= 1'b0;
            rd_en_q    <= 1'b0;
            over_q     <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            frame_q    <= '0;
            lat_q      <= '0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            single_q   <= single_d;
            wave_run_q <= (st_q == StCapt) || (st_q == StPend) || (st_q == StRead);
            rd_en_q    <= (st_q == StRead);
            over_q     <= (st_q == StRead) && (cnt_q == LastAddr);
            busy_q     <= (st_q != StIdle);
            if (st_q == StRead)  addr_q  <= cnt_q;
            if (st_q == StRearm) frame_q <= frame_q + 16'd1;
            lat_q[0] <= rd_en_q;
            for (int i = 1; i < RD_LAT; i++) lat_q[i] <= lat_q[i-1];
        end
    end

`ifdef DSO_AUTO_TRIG_EN
    logic [31:0] to_q;

    // Counts only consecutive CAPT cycles; any state change restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q    <= '0;
            force_q <= 1'b0;
        end else begin
            force_q <= 1'b0;
            if (st_q == StCapt && st_d == StCapt) begin
                if (to_q == 32'(AUTO_TIMEOUT - 1)) begin
                    to_q    <= '0;
                    force_q <= 1'b1;
                end else begin
                    to_q <= to_q + 32'd1;
                end
            end else begin
                to_q <= '0;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^AUTO_TIMEOUT;
    assign force_q        = 1'b0;
`endif

    assign bus.wave_run     = wave_run_q;
    assign bus.ram_rd_en    = rd_en_q;
    assign bus.wave_rd_addr = addr_q;
    assign bus.ram_rd_over  = over_q;
    assign bus.rd_valid     = lat_q[RD_LAT-1];
    assign bus.force_trig   = force_q;
    assign bus.busy         = busy_q;
    assign bus.frame_cnt    = frame_q;
endmodule

// File: tb/tb_dso_rd_sched.sv
// Bench for dso_rd_sched: vector table, directed frame sequences and a random
// run checked every cycle against a schedule-based reference model.
module tb_dso_rd_sched;
    localparam int unsigned POINTS       = 640;
    localparam int unsigned ADDR_W       = 10;
    localparam int unsigned RD_LAT       = 1;
    localparam int unsigned AUTO_TIMEOUT = 100;
    localparam int          MAXC         = 40000;
    localparam int          VW           = ADDR_W + 22;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dso_rd_sched_if #(.ADDR_W(ADDR_W)) bus ();

    dso_rd_sched #(
        .POINTS      (POINTS),
        .ADDR_W      (ADDR_W),
        .RD_LAT      (RD_LAT),
        .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: acquisition phase plus a per-edge schedule of read beats.
    typedef enum int {PIdle, PCapt, PPend, PRead, PRearm} phase_t;
    phase_t m_phase = PIdle;
    bit     m_single = 1'b0;
    int     m_cyc = 0;
    int     m_read_end = 0;
    int     m_hold = 0;
    int     m_frames = 0;
    int     m_to = 0;
    bit     m_force = 1'b0;
    bit     s_en    [MAXC];
    int     s_addr  [MAXC];
    bit     s_valid [MAXC];
    bit     s_frame [MAXC];
    logic [VW-1:0] exp_vec;

    int n_en, n_over, n_wr_low, n_force;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit run, input bit sng, input bit rdy,
                              input bit rds);
        int     c;
        phase_t nxt;
        bit     e_wr, e_en, e_over, e_val, e_busy;
        c = m_cyc;
        if (r) begin
            for (int i = c; i < c + int'(POINTS + RD_LAT) + 3 && i < MAXC; i++) begin
                s_en[i] = 1'b0; s_valid[i] = 1'b0; s_frame[i] = 1'b0;
            end
            exp_vec  = '0;
            m_phase  = PIdle;
            m_single = 1'b0;
            m_hold   = 0;
            m_frames = 0;
            m_to     = 0;
        end else begin
            nxt    = m_phase;
            e_wr   = m_phase inside {PCapt, PPend, PRead};
            e_busy = (m_phase != PIdle);
            e_en   = s_en[c];
            if (e_en) m_hold = s_addr[c];
            e_over = e_en && (s_addr[c] == int'(POINTS) - 1);
            e_val  = s_valid[c];
            if (s_frame[c]) m_frames = (m_frames + 1) % 65536;
            case (m_phase)
                PIdle: begin
                    if (run) begin
                        nxt = PCapt; m_single = 1'b0;
                    end else if (sng) begin
                        nxt = PCapt; m_single = 1'b1;
                    end
                end
                PCapt: begin
                    if (!run && !m_single) nxt = PIdle;
                    else if (rdy)          nxt = PPend;
                end
                PPend: begin
                    if (!run && !m_single) begin
                        nxt = PIdle;
                    end else if (rds) begin
                        nxt = PRead;
                        for (int k = 0; k < int'(POINTS); k++) begin
                            s_en[c + 1 + k]                  = 1'b1;
                            s_addr[c + 1 + k]                = k;
                            s_valid[c + 1 + k + int'(RD_LAT)] = 1'b1;
                        end
                        s_frame[c + int'(POINTS) + 1] = 1'b1;
                        m_read_end = c + int'(POINTS);
                    end
                end
                PRead: if (c == m_read_end) nxt = PRearm;
                PRearm: begin
                    nxt = (run && !m_single) ? PCapt : PIdle;
                    m_single = 1'b0;
                end
                default: nxt = PIdle;
            endcase
            m_force = 1'b0;
`ifdef DSO_AUTO_TRIG_EN
            if (m_phase == PCapt && nxt == PCapt) begin
                if (m_to == int'(AUTO_TIMEOUT) - 1) begin
                    m_force = 1'b1; m_to = 0;
                end else begin
                    m_to++;
                end
            end else begin
                m_to = 0;
            end
`endif
            exp_vec = {e_wr, e_en, ADDR_W'(m_hold), e_over, e_val, m_force, e_busy,
                       16'(m_frames)};
            m_phase = nxt;
        end
        m_cyc++;
    endtask

    task automatic tick(input bit r, input bit run, input bit sng, input bit rdy,
                        input bit rds);
        logic [VW-1:0] act;
        rst = r; bus.run_req = run; bus.single_req = sng; bus.wave_ready = rdy;
        bus.rd_start = rds;
        @(posedge clk);
        model_edge(r, run, sng, rdy, rds);
        @(negedge clk);
        act = {bus.wave_run, bus.ram_rd_en, bus.wave_rd_addr, bus.ram_rd_over, bus.rd_valid,
               bus.force_trig, bus.busy, bus.frame_cnt};
        total++;
        if (act !== exp_vec) begin
            bad++;
            $display("FAIL cycle %0d outputs {run,en,addr,over,valid,force,busy,frame}: got %h expected %h",
                     m_cyc, act, exp_vec);
        end
        if (bus.ram_rd_en)   n_en++;
        if (bus.ram_rd_over) n_over++;
        if (!bus.wave_run)   n_wr_low++;
        if (bus.force_trig)  n_force++;
    endtask

    task automatic clr_stats();
        n_en = 0; n_over = 0; n_wr_low = 0; n_force = 0;
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit r, run, sng, rdy, rds;
        logic [3:0] exp; // {wave_run, busy, ram_rd_en, ram_rd_over}
    } vec_t;
    vec_t tbl [16];

    bit r_run, r_rdy;

    initial begin
        clr_stats();
        tbl[0]  = '{1, 1, 0, 0, 0, 4'b0000};
        tbl[1]  = '{1, 1, 0, 0, 0, 4'b0000};
        tbl[2]  = '{0, 1, 0, 0, 0, 4'b0000};
        tbl[3]  = '{0, 1, 0, 0, 0, 4'b1100};
        tbl[4]  = '{0, 1, 0, 0, 1, 4'b1100};
        tbl[5]  = '{0, 1, 0, 1, 0, 4'b1100};
        tbl[6]  = '{0, 1, 0, 1, 0, 4'b1100};
        tbl[7]  = '{0, 0, 0, 1, 0, 4'b1100};
        tbl[8]  = '{0, 0, 0, 0, 0, 4'b0000};
        tbl[9]  = '{0, 0, 1, 0, 0, 4'b0000};
        tbl[10] = '{0, 0, 0, 0, 0, 4'b1100};
        tbl[11] = '{0, 0, 0, 1, 0, 4'b1100};
        tbl[12] = '{0, 0, 0, 1, 1, 4'b1100};
        tbl[13] = '{0, 0, 0, 0, 0, 4'b1110};
        tbl[14] = '{1, 0, 0, 0, 0, 4'b0000};
        tbl[15] = '{0, 0, 0, 0, 0, 4'b0000};
        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].r, tbl[i].run, tbl[i].sng, tbl[i].rdy, tbl[i].rds);
            chk($sformatf("tbl%0d", i),
                {bus.wave_run, bus.busy, bus.ram_rd_en, bus.ram_rd_over}, tbl[i].exp);
        end

        // Continuous frame.
        do_reset();
        for (int i = 0; i < 50; i++) tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 0);
        tick(0, 1, 0, 0, 1);
        clr_stats();
        for (int i = 0; i < 700; i++) tick(0, 1, 0, 0, 0);
        chk("cont_en_cycles", n_en, POINTS);
        chk("cont_over", n_over, 1);
        chk("cont_run_low", n_wr_low, 1);
        chk("cont_frame_cnt", bus.frame_cnt, 1);
        chk("cont_addr_hold", bus.wave_rd_addr, POINTS - 1);
        chk("cont_recapt", bus.wave_run, 1);

        // Single shot, with a stray single_req mid-frame.
        do_reset();
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1);
        clr_stats();
        for (int i = 0; i < 660; i++) tick(0, 0, (i == 100), 0, 0);
        chk("single_en_cycles", n_en, POINTS);
        chk("single_busy", bus.busy, 0);
        chk("single_frame_cnt", bus.frame_cnt, 1);
        clr_stats();
        tick(0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 1, 0);
        chk("single_no_reread", n_en, 0);

        // rd_start in CAPT and READ ignored; run dropped mid-frame.
        do_reset();
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 1, 0);
        tick(0, 1, 0, 0, 1);
        clr_stats();
        for (int i = 0; i < 100; i++) tick(0, 1, 0, 0, (i == 50));
        for (int i = 0; i < 600; i++) tick(0, 0, 0, 0, 0);
        chk("drop_en_cycles", n_en, POINTS);
        chk("drop_over", n_over, 1);
        chk("drop_busy", bus.busy, 0);
        chk("drop_frame_cnt", bus.frame_cnt, 1);

        // Reset at address 300.
        do_reset();
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 0);
        tick(0, 1, 0, 0, 1);
        clr_stats();
        for (int i = 0; i < 301; i++) tick(0, 1, 0, 0, 0);
        chk("abort_addr", bus.wave_rd_addr, 300);
        tick(1, 1, 0, 0, 0);
        chk("abort_en", bus.ram_rd_en, 0);
        chk("abort_addr_clr", bus.wave_rd_addr, 0);
        chk("abort_over", n_over, 0);
        chk("abort_frame_cnt", bus.frame_cnt, 0);

        // Long CAPT with no trigger.
        do_reset();
        tick(0, 1, 0, 0, 0);
        clr_stats();
        for (int i = 0; i < 250; i++) tick(0, 1, 0, 0, 0);
`ifdef DSO_AUTO_TRIG_EN
        chk("force_trig_pulses", n_force, 2);
`else
        chk("force_trig_pulses", n_force, 0);
`endif

        // Randomised traffic.
        do_reset();
        r_run = 1'b1;
        r_rdy = 1'b0;
        for (int i = 0; i < 12000 && m_cyc < MAXC - int'(POINTS) - 10; i++) begin
            if ($urandom_range(0, 399) == 0) r_run = ~r_run;
            if ($urandom_range(0, 29) == 0)  r_rdy = ~r_rdy;
            tick(($urandom_range(0, 2999) == 0), r_run, ($urandom_range(0, 49) == 0), r_rdy,
                 ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
